// File: rtl/mem_access_pkg.sv
// mem_access_pkg
// Shared definitions for the load/store sequencer:
//   - MIPS size/sign op codes carried on the 'op' request field
//   - FSM state encoding for mem_access_unit
//   - request legality check (illegal op code, sub-word store marked
//     unsigned, misaligned half/word access)
package mem_access_pkg;

    // Size/sign codes. Bit 2 set means a zero-extended load.
    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b011;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    // FSM state encoding.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    // True when a request must be rejected: unknown op code, an unsigned
    // code on a store, or a half/word access that is not naturally aligned.
    function automatic logic req_is_bad(
        input logic       wr,
        input logic [2:0] op,
        input logic [1:0] offset
    );
        logic bad;
        bad = 1'b0;
        case (op)
            OP_B:    bad = 1'b0;
            OP_H:    bad = offset[0];
            OP_W:    bad = (offset != 2'b00);
            OP_BU:   bad = wr;
            OP_HU:   bad = wr | offset[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align
// Combinational lane steering between a 32-bit RAM word and a byte/half/word
// access at a given byte offset (little-endian: byte k is bits 8k+7:8k).
// Ports:
//   word        in   32  RAM word (read data or previously read word)
//   offset      in   2   byte offset within the word (addr[1:0])
//   op          in   3   size/sign code (OP_B/OP_H/OP_W/OP_BU/OP_HU)
//   store_data  in   32  store data, lane to store in the low bits
//   store_word  out  32  'word' with the addressed byte/half replaced
//   load_value  out  32  addressed lane, sign- or zero-extended
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  op,
    input  logic [31:0] store_data,
    output logic [31:0] store_word,
    output logic [31:0] load_value
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Half accesses are aligned, so offset[1] alone selects the half.
    assign byte_lane = word[{offset, 3'b000} +: 8];
    assign half_lane = offset[1] ? word[31:16] : word[15:0];

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        store_word = word;
        load_value = word;
        case (op)
            OP_B, OP_BU: begin
                store_word[{offset, 3'b000} +: 8] = store_data[7:0];
                load_value = (op == OP_B) ? {{24{byte_lane[7]}}, byte_lane}
                                          : {24'h000000, byte_lane};
            end
            OP_H, OP_HU: begin
                if (offset[1]) begin
                    store_word[31:16] = store_data[15:0];
                end else begin
                    store_word[15:0] = store_data[15:0];
                end
                load_value = (op == OP_H) ? {{16{half_lane[15]}}, half_lane}
                                          : {16'h0000, half_lane};
            end
            default: begin
                store_word = store_data;
                load_value = word;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Load/store sequencer in front of a word RAM (synchronous write,
// combinational read). Accepts byte-addressed MIPS loads/stores, performs
// word reads/writes (read-modify-write for SB/SH), returns extended load
// data with a one-cycle done pulse and flags illegal/misaligned requests.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   req, wr, op,      request strobe, store flag, size/sign code,
//   addr, wdata       byte address, store data (lane in low bits)
//   ready, busy       request accepted on an edge with req & ready
//   done, err, rdata  completion pulse, error flag, held load result
//   ram_addr, ram_d,  RAM word address, write data, write enable
//   ram_we, ram_q     and combinational read data
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int WORD_AW = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    input  logic                 wr,
    input  logic [2:0]           op,
    input  logic [WORD_AW+1:0]   addr,
    input  logic [31:0]          wdata,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [31:0]          rdata,
    output logic [WORD_AW-1:0]   ram_addr,
    output logic [31:0]          ram_d,
    output logic                 ram_we,
    input  logic [31:0]          ram_q
);

    logic [2:0]         state_q, state_d;
    logic [WORD_AW+1:0] addr_q,  addr_d;
    logic [2:0]         op_q,    op_d;
    logic               wr_q,    wr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        word_q,  word_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [31:0] align_word;
    logic [31:0] store_word;
    logic [31:0] load_value;

    // During READ the lanes come straight from the RAM; during WRITE they
    // come from the word captured at the end of READ.
    assign align_word = (state_q == ST_READ) ? ram_q : word_q;

    mem_lane_align u_align (
        .word       (align_word),
        .offset     (addr_q[1:0]),
        .op         (op_q),
        .store_data (wdata_q),
        .store_word (store_word),
        .load_value (load_value)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        op_d    = op_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    addr_d  = addr;
                    op_d    = op;
                    wr_d    = wr;
                    wdata_d = wdata;
                    if (req_is_bad(wr, op, addr[1:0])) begin
                        state_d = ST_ERR;
                    end else if (wr && (op == OP_W)) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                word_d = ram_q;
                if (wr_q) begin
                    state_d = ST_WRITE;
                end else begin
                    rdata_d = load_value;
                    state_d = ST_DONE;
                end
            end
            ST_WRITE: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it is tested inside the clocked block; state uses <= only.
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            op_q    <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
        end
    end

    assign ready    = (state_q == ST_IDLE);
    assign busy     = ~ready;
    assign done     = (state_q == ST_DONE) | (state_q == ST_ERR);
    assign err      = (state_q == ST_ERR);
    assign rdata    = rdata_q;
    assign ram_addr = addr_q[WORD_AW+1:2];

    // Gating with rst_n lets a reset that lands on the WRITE cycle kill the
    // write in that same cycle rather than one edge later.
    assign ram_we = (state_q == ST_WRITE) & rst_n;
    assign ram_d  = !ram_we          ? 32'h0000_0000 :
                    (op_q == OP_W)   ? wdata_q       : store_word;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store sequencer that sits directly upstream of the data-memory word RAM. The RAM has 10-bit word address, 32-bit data, synchronous write and combinational read.
- Takes byte-addressed MIPS memory requests (LB/LBU/LH/LHU/LW/SB/SH/SW) from the MEM stage.
- Converts them into word-RAM reads and writes; sub-word stores use read-modify-write.
- Returns aligned, extended load data with a done pulse.
- Flags misaligned or illegal requests.

Parameters:
WORD_AW, 10, RAM word-address width; byte address width is WORD_AW+2.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  reset, synchronous, active-low.
req  input  1  request strobe; sampled only when ready=1.
wr  input  1  1=store, 0=load.
op  input  3  size/sign code: 000 byte, 001 half, 011 word, 100 byte-unsigned, 101 half-unsigned.
addr  input  WORD_AW+2  byte address.
wdata  input  32  store data; the lane to store is in the low bits.
ready  output  1  high in IDLE only; request accepted on edge where req&ready.
busy  output  1  ~ready.
done  output  1  one-cycle pulse: request completed.
err  output  1  valid with done; request was misaligned/illegal.
rdata  output  32  load result; held until next done.
ram_addr  output  WORD_AW  word address to RAM = addr_r[WORD_AW+1:2].
ram_d  output  32  write data to RAM.
ram_we  output  1  RAM write enable.
ram_q  input  32  RAM combinational read data.

Behaviour:
- Reset (rst_n=0 at a rising edge) forces the following:
  - state=IDLE; done=0, err=0, rdata=0; addr_r/op_r/wr_r/wdata_r=0 (so ram_addr=0).
  - ram_d=0, ram_we=0.
- ram_we = (state==WRITE) & rst_n. A reset asserted during the WRITE cycle suppresses that write, and the store is aborted.
- Byte order is little-endian: byte k occupies bits 8k+7:8k; the half at offset 2 occupies bits 31:16.
- States: IDLE, READ, WRITE, DONE, ERR.
- IDLE: on req, latch wr/op/addr/wdata, then select the next state:
  - ERR if any of these hold: op in {010,110,111}; wr=1 with op in {100,101}; half with addr[0]=1; word with addr[1:0]!=0.
  - WRITE for a word store.
  - READ otherwise.
- READ: ram_addr valid; at the edge, capture ram_q into word_r, then:
  - load → DONE;
  - sub-word store → WRITE.
- WRITE:
  - word store: ram_d = wdata_r.
  - sub-word store: ram_d = word_r with the addressed byte/half replaced by wdata_r[7:0]/[15:0].
  - Next state is DONE.
- DONE: done=1, err=0. For loads, rdata updates at the READ→DONE edge: the selected lane is sign-extended for codes 000/001 and zero-extended for 100/101. Next state is IDLE.
- ERR: done=1, err=1, no RAM write, rdata unchanged. Next state is IDLE.
- Latency from the accept edge to the done cycle:
  - LW/LB/LH and unsigned loads: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - error: 1 cycle.
- A req while busy is ignored and not queued; the requester holds req until it sees ready.
- The earliest back-to-back acceptance is the cycle after DONE/ERR (state IDLE).
- Inputs other than req are don't-care outside the accept cycle.

Decomposition:
- Package mem_access_pkg: op codes (OP_B, OP_H, OP_W, OP_BU, OP_HU), the state encoding, and the misalignment-check function.
- One combinational sub-module mem_lane_align: given word, offset, op and store data, it produces the merged store word and the extended load value. The FSM stays in mem_access_unit.

Test Plan:
- Each test below sets rst_n=0 for two cycles first; its preconditions are preloaded into the RAM model.
- Reset check -> after reset, ready=1, done=0, err=0, rdata=0, ram_we=0.
- SW addr=0x010 wdata=0xDEADBEEF -> ram_we=1 for exactly 1 cycle at word 4, done 2 cycles after accept; then LW 0x010 -> rdata=0xDEADBEEF, 2-cycle latency.
- Word 4=0xDEADBEEF; LB 0x013 -> rdata=0xFFFFFFDE; LBU 0x013 -> 0x000000DE; LH 0x012 -> 0xFFFFDEAD; LHU 0x010 -> 0x0000BEEF.
- Word 4=0xDEADBEEF; SB 0x011 wdata=0x12 -> word 4=0xDEAD12EF, 3-cycle latency, exactly one ram_we pulse; SH 0x012 wdata=0x5678 -> 0x567812EF.
- LW 0x011, SH 0x013, op=110, SBU (wr=1 op=100) -> each gives done=err=1 one cycle after accept, no ram_we, rdata unchanged.
- Reset mid-operation: rst_n=0 in the WRITE cycle of SB 0x020 -> ram_we stays 0, RAM word 8 unchanged, state IDLE. Separately, req held during busy -> only one transaction is performed.
